// File: rtl/rr_stream_arbiter.sv
// -----------------------------------------------------------------------------
// rr_stream_arbiter
//
// Round-robin arbiter that merges NUM_ELEM valid/ready input streams into one
// registered output stream. The winning source index is presented on o_sel_o
// alongside the data so a downstream mux can steer matching sideband data.
//
// Parameters:
//   ELEM_WIDTH  width of each data element
//   NUM_ELEM    number of input streams (2..256)
//
// Ports:
//   clk_i       clock, rising edge
//   arst_i      asynchronous reset, active-high
//   i_data_i    packed per-source data, source 0 in the LSBs
//   i_valid_i   per-source valid
//   i_ready_o   per-source ready, one-hot or zero
//   i_last_i    per-source end-of-packet flag  (RR_STREAM_ARBITER_PACKET_EN only)
//   o_last_o    registered end-of-packet flag  (RR_STREAM_ARBITER_PACKET_EN only)
//   o_data_o    registered output data
//   o_sel_o     registered index of the source that produced o_data_o
//   o_valid_o   registered output valid
//   o_ready_i   downstream ready
//
// Optional feature macro: RR_STREAM_ARBITER_PACKET_EN
//   When defined, a beat with last=0 locks the grant onto that source until
//   its last=1 beat has been accepted, so packets are never interleaved.
// -----------------------------------------------------------------------------
module rr_stream_arbiter #(
  parameter int ELEM_WIDTH = 8,
  parameter int NUM_ELEM   = 6
) (
  input  logic                                clk_i,
  input  logic                                arst_i,
  input  logic [NUM_ELEM-1:0][ELEM_WIDTH-1:0] i_data_i,
  input  logic [NUM_ELEM-1:0]                 i_valid_i,
  output logic [NUM_ELEM-1:0]                 i_ready_o,
`ifdef RR_STREAM_ARBITER_PACKET_EN
  input  logic [NUM_ELEM-1:0]                 i_last_i,
  output logic                                o_last_o,
`endif
  output logic [ELEM_WIDTH-1:0]               o_data_o,
  output logic [$clog2(NUM_ELEM)-1:0]         o_sel_o,
  output logic                                o_valid_o,
  input  logic                                o_ready_i
);

  localparam int SEL_W = $clog2(NUM_ELEM);

  typedef logic [SEL_W-1:0] sel_t;
  // One extra bit so ptr + offset never overflows before the wrap correction.
  typedef logic [SEL_W:0]   ext_t;

  // First requesting index scanning start, start+1, ..., wrapping at NUM_ELEM.
  function automatic sel_t rr_pick(input logic [NUM_ELEM-1:0] req, input sel_t start);
    sel_t pick;
    logic found;
    ext_t idx;
    pick  = start;
    found = 1'b0;
    for (int off = 0; off < NUM_ELEM; off++) begin
      idx = ext_t'(start) + ext_t'(off);
      if (idx >= ext_t'(NUM_ELEM)) idx = idx - ext_t'(NUM_ELEM);
      if (!found && req[idx[SEL_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[SEL_W-1:0];
      end
    end
    return pick;
  endfunction

  logic [ELEM_WIDTH-1:0] data_q, data_d;
  sel_t                  sel_q, sel_d;
  sel_t                  ptr_q, ptr_d;
  logic                  valid_q, valid_d;

  logic load;      // output register can take a new element this cycle
  logic req_any;   // the granted source (or any source when unlocked) is requesting
  logic hs;        // input handshake with the granted source
  sel_t rr_grant;
  sel_t grant;
  sel_t grant_inc;

  assign load      = ~valid_q | o_ready_i;
  assign rr_grant  = rr_pick(i_valid_i, ptr_q);
  assign grant_inc = (grant == sel_t'(NUM_ELEM - 1)) ? '0 : grant + sel_t'(1);

`ifdef RR_STREAM_ARBITER_PACKET_EN
  logic lock_q, lock_d;
  logic last_q, last_d;

  // While locked, sel_q still holds the index of the packet in flight, so it
  // doubles as the lock owner. An idle owner blocks everyone else.
  assign grant   = lock_q ? sel_q : rr_grant;
  assign req_any = lock_q ? i_valid_i[sel_q] : |i_valid_i;
`else
  assign grant   = rr_grant;
  assign req_any = |i_valid_i;
`endif

  assign hs = load & req_any;

  // Ready is held low during reset so no source believes it was accepted by
  // a register that is being cleared.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    i_ready_o = '0;
    if (hs && !arst_i) i_ready_o[grant] = 1'b1;
  end

  always_comb begin
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
`ifdef RR_STREAM_ARBITER_PACKET_EN
    lock_d  = lock_q;
    last_d  = last_q;
`endif
    if (load) begin
      // Consumed or empty output: refill if someone handshakes, else go empty.
      valid_d = hs;
      if (hs) begin
        data_d = i_data_i[grant];
        sel_d  = grant;
`ifdef RR_STREAM_ARBITER_PACKET_EN
        last_d = i_last_i[grant];
        lock_d = ~i_last_i[grant];
        // Priority only moves on once the packet is complete.
        if (i_last_i[grant]) ptr_d = grant_inc;
`else
        ptr_d  = grant_inc;
`endif
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
`ifdef RR_STREAM_ARBITER_PACKET_EN
      lock_q  <= 1'b0;
      last_q  <= 1'b0;
`endif
    end else begin
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
`ifdef RR_STREAM_ARBITER_PACKET_EN
      lock_q  <= lock_d;
      last_q  <= last_d;
`endif
    end
  end

  assign o_data_o  = data_q;
  assign o_sel_o   = sel_q;
  assign o_valid_o = valid_q;
`ifdef RR_STREAM_ARBITER_PACKET_EN
  assign o_last_o  = last_q;
`endif

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_stream_arbiter
//
// Self-checking bench for rr_stream_arbiter (NUM_ELEM=6, ELEM_WIDTH=8).
// Directed table and hand-written sequences cover reset, contention,
// backpressure, wrap, mid-stream reset and (with the packet macro) locking;
// a randomized phase is compared against a queue-free arithmetic model.
// -----------------------------------------------------------------------------
module tb_rr_stream_arbiter;

  localparam int N = 6;
  localparam int W = 8;

  logic                clk = 1'b0;
  logic                arst;
  logic [N-1:0][W-1:0] data;
  logic [N-1:0]        valid;
  logic [N-1:0]        ready;
  logic [N-1:0]        last;
  logic [W-1:0]        o_data;
  logic [2:0]          o_sel;
  logic                o_valid;
  logic                o_ready;
`ifdef RR_STREAM_ARBITER_PACKET_EN
  logic                o_last;
`endif

  always #5 clk = ~clk;

  rr_stream_arbiter #(.ELEM_WIDTH(W), .NUM_ELEM(N)) dut (
    .clk_i     (clk),
    .arst_i    (arst),
    .i_data_i  (data),
    .i_valid_i (valid),
    .i_ready_o (ready),
`ifdef RR_STREAM_ARBITER_PACKET_EN
    .i_last_i  (last),
    .o_last_o  (o_last),
`endif
    .o_data_o  (o_data),
    .o_sel_o   (o_sel),
    .o_valid_o (o_valid),
    .o_ready_i (o_ready)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: state of the output register plus the rotating priority.
  // ---------------------------------------------------------------------------
  int         m_ptr;
  logic [2:0] m_sel;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_lock;
  logic       m_last;

  function automatic void model_reset();
    m_ptr = 0; m_sel = '0; m_data = '0; m_valid = 1'b0; m_lock = 1'b0; m_last = 1'b0;
  endfunction

  // Winner under the spec rules, or -1 when nobody is eligible.
  function automatic int model_grant(input logic [N-1:0] v);
    int idx;
    if (m_lock) return v[m_sel] ? int'(m_sel) : -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (v[idx[2:0]]) return idx;
    end
    return -1;
  endfunction

  // One clock cycle: drive, check ready before the edge, update model at the
  // edge, check registered outputs after it.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] lst, input logic ordy,
                      output logic [N-1:0] rdy_seen);
    int           g;
    logic         ld;
    logic [N-1:0] exp_rdy;
    logic [N*W-1:0] flat;
    valid   = v;
    last    = lst;
    o_ready = ordy;
    #1;
    ld      = !m_valid || ordy;
    g       = model_grant(v);
    exp_rdy = (ld && g >= 0) ? (N'(1) << g) : '0;
    rdy_seen = ready;
    check("i_ready", 32'(ready), 32'(exp_rdy));
    flat = data;
    @(posedge clk);
    if (ld) begin
      if (g >= 0) begin
        m_data  = flat[g*W +: W];
        m_sel   = 3'(g);
        m_valid = 1'b1;
        m_last  = lst[g];
        m_lock  = !lst[g];
        if (lst[g]) m_ptr = (g + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    check("o_valid", 32'(o_valid), 32'(m_valid));
    check("o_sel",   32'(o_sel),   32'(m_sel));
    check("o_data",  32'(o_data),  32'(m_data));
`ifdef RR_STREAM_ARBITER_PACKET_EN
    check("o_last",  32'(o_last),  32'(m_last));
`endif
  endtask

  // Assert reset (asynchronously, mid-cycle) and hold it for ncyc edges.
  task automatic do_reset(input int ncyc);
    arst = 1'b1;
    #1;
    check("rst_async_valid", 32'(o_valid), 32'd0);
    check("rst_async_ready", 32'(ready),   32'd0);
    check("rst_async_data",  32'(o_data),  32'd0);
    repeat (ncyc) begin
      @(posedge clk);
      #1;
      check("rst_ready", 32'(ready),   32'd0);
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_sel",   32'(o_sel),   32'd0);
    end
    arst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [N-1:0] v;
    logic         ordy;
    logic [N-1:0] exp_ready;
    logic [2:0]   exp_sel;
    logic [7:0]   exp_data;
  } vec_t;

  vec_t         tbl[7];
  logic [N-1:0] rs;
  logic [N-1:0] all_last;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    all_last = '1;
    for (int k = 0; k < N; k++) data[k] = 8'(8'h10 + k);
    valid   = '1;
    last    = all_last;
    o_ready = 1'b1;
    model_reset();

    // Reset with every source requesting.
    do_reset(3);

    // Full contention: strict rotation, one beat per cycle.
    tbl[0] = '{6'h3F, 1'b1, 6'b000001, 3'd0, 8'h10};
    tbl[1] = '{6'h3F, 1'b1, 6'b000010, 3'd1, 8'h11};
    tbl[2] = '{6'h3F, 1'b1, 6'b000100, 3'd2, 8'h12};
    tbl[3] = '{6'h3F, 1'b1, 6'b001000, 3'd3, 8'h13};
    tbl[4] = '{6'h3F, 1'b1, 6'b010000, 3'd4, 8'h14};
    tbl[5] = '{6'h3F, 1'b1, 6'b100000, 3'd5, 8'h15};
    tbl[6] = '{6'h3F, 1'b1, 6'b000001, 3'd0, 8'h10};
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].v, all_last, tbl[i].ordy, rs);
      check($sformatf("tbl%0d_ready", i), 32'(rs),      32'(tbl[i].exp_ready));
      check($sformatf("tbl%0d_sel", i),   32'(o_sel),   32'(tbl[i].exp_sel));
      check($sformatf("tbl%0d_data", i),  32'(o_data),  32'(tbl[i].exp_data));
      check($sformatf("tbl%0d_valid", i), 32'(o_valid), 32'd1);
    end

    // Backpressure: sources 2 and 4, stall for 4 cycles after the first accept.
    step(6'b010100, all_last, 1'b1, rs);
    check("bp_first_data", 32'(o_data), 32'h12);
    for (int i = 0; i < 4; i++) begin
      step(6'b010100, all_last, 1'b0, rs);
      check("bp_stall_ready", 32'(rs),     32'd0);
      check("bp_hold_data",   32'(o_data), 32'h12);
    end
    step(6'b010100, all_last, 1'b1, rs);
    check("bp_release_data", 32'(o_data), 32'h14);
    check("bp_release_sel",  32'(o_sel),  32'd4);

    // Wrap and skip: ptr=5, only sources 1 and 3 requesting.
    step(6'b001010, all_last, 1'b1, rs);
    check("wrap_sel0", 32'(o_sel), 32'd1);
    step(6'b001010, all_last, 1'b1, rs);
    check("wrap_sel1", 32'(o_sel), 32'd3);
    step(6'b001010, all_last, 1'b1, rs);
    check("wrap_sel2", 32'(o_sel), 32'd1);

    // Mid-stream reset while a beat is held under backpressure.
    step(6'b001000, all_last, 1'b0, rs);
    check("mid_held_valid", 32'(o_valid), 32'd1);
    check("mid_held_data",  32'(o_data),  32'h11);
    do_reset(2);
    step(6'b001001, all_last, 1'b1, rs);
    check("mid_restart_sel",  32'(o_sel),  32'd0);
    check("mid_restart_data", 32'(o_data), 32'h10);
    step(6'b001001, all_last, 1'b1, rs);
    check("mid_next_sel", 32'(o_sel), 32'd3);
    step(6'b000000, all_last, 1'b1, rs);
    check("mid_drain_valid", 32'(o_valid), 32'd0);

`ifdef RR_STREAM_ARBITER_PACKET_EN
    // Packet lock: source 3 sends 3 beats while source 0 keeps requesting.
    do_reset(1);
    step(6'b000100, all_last, 1'b1, rs);      // ptr -> 3
    check("pkt_pre_sel", 32'(o_sel), 32'd2);
    for (int b = 0; b < 3; b++) begin
      step(6'b001001, (b == 2) ? all_last : 6'b110111, 1'b1, rs);
      check($sformatf("pkt_beat%0d_ready", b), 32'(rs),    32'b001000);
      check($sformatf("pkt_beat%0d_sel", b),   32'(o_sel), 32'd3);
    end
    step(6'b000001, all_last, 1'b1, rs);
    check("pkt_after_sel", 32'(o_sel), 32'd0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] v;
      logic [N-1:0] lst;
      for (int k = 0; k < N; k++) data[k] = 8'($urandom);
      v = N'($urandom);
      if ($urandom_range(3) == 0) v = v & N'($urandom);
      lst = all_last;
`ifdef RR_STREAM_ARBITER_PACKET_EN
      lst = N'($urandom) | N'($urandom);
`endif
      step(v, lst, ($urandom_range(3) != 0), rs);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
